// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone classic initiator.
// Build option: WB_INITIATOR_TIMEOUT_EN enables the REQ watchdog in wb_initiator.
package wb_initiator_pkg;

    // Bus-cycle sequencing states; busy_o and wbm_cyc_o are "not IDLE".
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_REQ   = 2'd2,
        ST_RSP   = 2'd3
    } state_e;

    // Byte distance between consecutive beats of an incrementing burst.
    function automatic int unsigned byte_stride(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/wb_initiator_wdog.sv
// REQ watchdog for wb_initiator: counts cycles while enabled, flags expiry
// on the cycle whose closing edge is the TIMEOUT_CYCLES-th edge spent in REQ.
// Only instantiated when WB_INITIATOR_TIMEOUT_EN is defined.
module wb_initiator_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear outside REQ, count up to the limit inside it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count starts at 0 on REQ entry, so LIMIT is reached just before
    // the TIMEOUT_CYCLES-th edge; the state machine leaves REQ on that edge.
    assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: converts a valid/ready command stream into
// single or incrementing-burst bus cycles with one response per beat.
// Build option: WB_INITIATOR_TIMEOUT_EN adds a REQ watchdog that ends a
// stalled beat as an error after TIMEOUT_CYCLES cycles.
module wb_initiator #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [AW-1:0]     cmd_adr_i,
    input  logic [DW/8-1:0]   cmd_sel_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              wdata_valid_i,
    output logic              wdata_ready_o,
    input  logic [DW-1:0]     wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DW-1:0]     rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_last_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [AW-1:0]     wbm_adr_o,
    output logic [DW/8-1:0]   wbm_sel_o,
    output logic [DW-1:0]     wbm_dat_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    input  logic [DW-1:0]     wbm_dat_i,
    output logic              busy_o
);

    import wb_initiator_pkg::*;

    localparam int            SW         = DW / 8;
    localparam logic [AW-1:0] ADR_STRIDE = AW'(byte_stride(DW));

    state_e           state_q, state_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic             we_q, we_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [DW-1:0]    wdat_q, wdat_d;
    logic [DW-1:0]    rdat_q, rdat_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             tmo_expired;
    logic             last_beat;

`ifdef WB_INITIATOR_TIMEOUT_EN
    wb_initiator_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .clr_i     (state_q != ST_REQ),
        .en_i      (state_q == ST_REQ),
        .expired_o (tmo_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign tmo_expired    = 1'b0;
`endif

    // A beat ends the command when it was the final one or it failed.
    assign last_beat = (remaining_q == '0) || err_q;

    // Next-state and datapath capture for the bus sequencer.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        adr_d       = adr_q;
        we_d        = we_q;
        sel_d       = sel_q;
        wdat_d      = wdat_q;
        rdat_d      = rdat_q;
        err_d       = err_q;
        remaining_d = remaining_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    adr_d       = cmd_adr_i;
                    we_d        = cmd_we_i;
                    sel_d       = cmd_sel_i;
                    remaining_d = cmd_len_i;
                    err_d       = 1'b0;
                    state_d     = cmd_we_i ? ST_WDATA : ST_REQ;
                end
            end
            ST_WDATA: begin
                if (wdata_valid_i) begin
                    wdat_d  = wdata_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Error (from the slave or the watchdog) wins over ack.
                if (wbm_err_i || tmo_expired) begin
                    err_d   = 1'b1;
                    rdat_d  = '0;
                    state_d = ST_RSP;
                end else if (wbm_ack_i) begin
                    rdat_d  = we_q ? '0 : wbm_dat_i;
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready_i) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        remaining_d = remaining_q - LEN_W'(1);
                        adr_d       = adr_q + ADR_STRIDE;
                        state_d     = we_q ? ST_WDATA : ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight beat.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            wdat_q      <= '0;
            rdat_q      <= '0;
            err_q       <= 1'b0;
            remaining_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            wdat_q      <= wdat_d;
            rdat_q      <= rdat_d;
            err_q       <= err_d;
            remaining_q <= remaining_d;
        end
    end

    // Outputs are registers or state decodes only; no path from wbm_ack_i.
    assign cmd_ready_o   = (state_q == ST_IDLE);
    assign wdata_ready_o = (state_q == ST_WDATA);
    assign rsp_valid_o   = (state_q == ST_RSP);
    assign rsp_dat_o     = rdat_q;
    assign rsp_err_o     = rsp_valid_o && err_q;
    assign rsp_last_o    = rsp_valid_o && last_beat;
    assign wbm_cyc_o     = (state_q != ST_IDLE);
    assign wbm_stb_o     = (state_q == ST_REQ);
    assign wbm_we_o      = we_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_sel_o     = sel_q;
    assign wbm_dat_o     = wdat_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: directed scenarios plus randomized
// commands, a memory-backed Wishbone slave model and a response scoreboard.
module tb_wb_initiator;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LW  = 8;
    localparam int TMO = 16;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_n_i;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [3:0]    cmd_sel_i;
    logic [LW-1:0] cmd_len_i;
    logic          wdata_valid_i, wdata_ready_o;
    logic [DW-1:0] wdata_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_last_o;
    logic [DW-1:0] rsp_dat_o;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [AW-1:0] wbm_adr_o;
    logic [3:0]    wbm_sel_o;
    logic [DW-1:0] wbm_dat_o;
    logic          wbm_ack_i, wbm_err_i;
    logic [DW-1:0] wbm_dat_i;
    logic          busy_o;

    wb_initiator #(.AW(AW), .DW(DW), .LEN_W(LW), .TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_len_i(cmd_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .rsp_last_o(rsp_last_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i),
        .busy_o(busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct { logic [31:0] dat; logic err; logic last; } rsp_t;
    typedef struct { logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; } bus_t;

    rsp_t        exp_rsp[$];
    bus_t        exp_bus[$];
    logic [31:0] wq[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    bit active = 0, chk_idle = 0;
    bit rsp_rand = 0, wd_rand = 0, wd_pending = 0;
    int rsp_stall = 0;
    int slv_waits = 0, slv_err_beat = -1, slv_hold_beat = -1, slv_beat = 0, wait_left = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Unwritten locations read as an address-derived pattern.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(posedge wb_clk_i) cyc_cnt++;

    // Slave model: drives ack/err/data at negedge for the next rising edge.
    always @(negedge wb_clk_i) begin
        bus_t b;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = $urandom;
        if (!wbm_stb_o) begin
            wait_left = -1;
        end else if (slv_beat != slv_hold_beat) begin
            if (wait_left < 0) wait_left = (slv_waits >= 0) ? slv_waits : $urandom_range(0, 3);
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                wait_left = -1;
                check("bus_cyc", wbm_cyc_o, 1);
                check("bus_beat_expected", exp_bus.size() != 0, 1);
                if (exp_bus.size() != 0) begin
                    b = exp_bus.pop_front();
                    check("bus_adr", wbm_adr_o, b.adr);
                    check("bus_we", wbm_we_o, b.we);
                    check("bus_sel", wbm_sel_o, b.sel);
                    if (b.we) check("bus_dat", wbm_dat_o, b.dat);
                end
                wbm_ack_i = 1'b1;
                if (slv_beat == slv_err_beat) wbm_err_i = 1'b1;
                else if (wbm_we_o) slv_mem[wbm_adr_o] = merge(slv_rd(wbm_adr_o), wbm_dat_o, wbm_sel_o);
                else wbm_dat_i = slv_rd(wbm_adr_o);
                slv_beat++;
            end
        end
    end

    // Write-data feeder: presents queued data, pops after a handshake edge.
    always @(negedge wb_clk_i) begin
        if (wd_pending && wq.size() != 0) void'(wq.pop_front());
        wd_pending = 1'b0;
        if (wq.size() != 0 && (!wd_rand || $urandom_range(0, 2) != 0)) begin
            wdata_valid_i = 1'b1;
            wdata_i       = wq[0];
            wd_pending    = wdata_ready_o;
        end else begin
            wdata_valid_i = 1'b0;
            wdata_i       = $urandom;
        end
    end

    // Response monitor: drives rsp_ready_i and compares against the scoreboard.
    always @(negedge wb_clk_i) begin
        rsp_t e;
        if (chk_idle) begin
            chk_idle = 1'b0;
            check("idle_cyc", wbm_cyc_o, 0);
            check("idle_busy", busy_o, 0);
            check("idle_cmd_ready", cmd_ready_o, 1);
        end
        if (active) check("cyc_held", wbm_cyc_o, 1);
        if (rsp_valid_o) begin
            if (rsp_stall > 0) begin
                rsp_ready_i = 1'b0;
                rsp_stall--;
            end else begin
                rsp_ready_i = rsp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            check("rsp_expected", exp_rsp.size() != 0, 1);
            if (exp_rsp.size() != 0) begin
                e = exp_rsp[0];
                check("rsp_dat", rsp_dat_o, e.dat);
                check("rsp_err", rsp_err_o, e.err);
                check("rsp_last", rsp_last_o, e.last);
                check("rsp_no_stb", wbm_stb_o, 0);
                if (rsp_ready_i) begin
                    void'(exp_rsp.pop_front());
                    if (e.last) begin
                        active   = 1'b0;
                        chk_idle = 1'b1;
                    end
                end
            end
        end else begin
            rsp_ready_i = rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        slv_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // Builds the expected beats from the command, then performs the handshake.
    task automatic issue(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                         input int len, input int err_beat, input int hold_beat,
                         input bit tmo_exp, input bit inc_data);
        logic [31:0] a, d;
        @(negedge wb_clk_i);
        slv_beat = 0; slv_err_beat = err_beat; slv_hold_beat = hold_beat;
        for (int i = 0; i <= len; i++) begin
            a = adr + 32'(i * 4);
            d = inc_data ? 32'(i + 1) : $urandom;
            if (we) wq.push_back(d);
            if (i == hold_beat) begin
                if (tmo_exp) exp_rsp.push_back('{dat: 32'h0, err: 1'b1, last: 1'b1});
                break;
            end
            exp_bus.push_back('{adr: a, we: we, sel: sel, dat: d});
            if (i == err_beat) begin
                exp_rsp.push_back('{dat: 32'h0, err: 1'b1, last: 1'b1});
                break;
            end
            if (we) ref_mem[a] = merge(ref_rd(a), d, sel);
            exp_rsp.push_back('{dat: (we ? 32'h0 : ref_rd(a)), err: 1'b0, last: (i == len)});
        end
        cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_len_i = LW'(len);
        cmd_valid_i = 1'b1;
        check("cmd_ready_idle", cmd_ready_o, 1);
        @(posedge wb_clk_i);
        active = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        cmd_adr_i   = $urandom;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while ((exp_rsp.size() != 0 || active) && c < budget) begin
            @(negedge wb_clk_i);
            c++;
        end
        check("done_in_budget", c < budget, 1);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        check("bus_all_beats", exp_bus.size(), 0);
        wq.delete();
    endtask

    task automatic reset_mid();
        @(posedge wb_clk_i);
        #2;
        active = 1'b0;
        wb_rst_n_i = 1'b0;
        #1;
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        slv_hold_beat = -1;
        exp_bus.delete(); exp_rsp.delete(); wq.delete();
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_busy", busy_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c, t0, t1;
        logic [31:0] a;
        int len, eb;
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_sel_i = '0; cmd_len_i = '0;
        wb_rst_n_i = 1'b1;
        #1 wb_rst_n_i = 1'b0;
        #2;
        check("reset_cmd_ready", cmd_ready_o, 1);
        check("reset_cyc", wbm_cyc_o, 0);
        check("reset_stb", wbm_stb_o, 0);
        check("reset_we", wbm_we_o, 0);
        check("reset_adr", wbm_adr_o, 0);
        check("reset_sel", wbm_sel_o, 0);
        check("reset_wbm_dat", wbm_dat_o, 0);
        check("reset_rsp_valid", rsp_valid_o, 0);
        check("reset_rsp_dat", rsp_dat_o, 0);
        check("reset_rsp_err", rsp_err_o, 0);
        check("reset_rsp_last", rsp_last_o, 0);
        check("reset_wdata_ready", wdata_ready_o, 0);
        check("reset_busy", busy_o, 0);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;

        // Single read with two wait states.
        preload(32'h3000_0004, 32'hDEAD_BEEF);
        slv_waits = 2;
        issue(0, 32'h3000_0004, 4'hF, 0, -1, -1, 0, 0);
        wait_done(100);

        // Write burst of 1..4, a command attempt while busy, then read back.
        slv_waits = 0;
        issue(1, 32'h3000_0000, 4'hF, 3, -1, -1, 0, 1);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b1;
        check("cmd_ready_busy", cmd_ready_o, 0);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        wait_done(200);
        issue(0, 32'h3000_0000, 4'hF, 3, -1, -1, 0, 0);
        wait_done(200);

        // Response backpressure on beat 0.
        slv_waits = 1;
        rsp_stall = 5;
        issue(0, 32'h3000_0040, 4'hF, 1, -1, -1, 0, 0);
        wait_done(200);

        // Error together with ack on beat 1 of a 4-beat read.
        slv_waits = 0;
        issue(0, 32'h3000_0080, 4'hF, 3, 1, -1, 0, 0);
        wait_done(200);

        // Reset while beat 2 is waiting in REQ, then a clean single read.
        issue(0, 32'h3000_0100, 4'hF, 3, -1, 2, 0, 0);
        c = 0;
        while (!(exp_rsp.size() == 0 && wbm_stb_o) && c < 100) begin
            @(negedge wb_clk_i);
            c++;
        end
        check("reach_beat2_req", c < 100, 1);
        reset_mid();
        issue(0, 32'h3000_0200, 4'hF, 0, -1, -1, 0, 0);
        wait_done(100);

        // Slave that never answers.
`ifdef WB_INITIATOR_TIMEOUT_EN
        issue(0, 32'h3000_0300, 4'hF, 2, -1, 0, 1, 0);
        c = 0;
        while (!wbm_stb_o && c < 50) begin @(negedge wb_clk_i); c++; end
        t0 = cyc_cnt;
        while (!rsp_valid_o && c < 100) begin @(negedge wb_clk_i); c++; end
        t1 = cyc_cnt;
        check("timeout_latency", t1 - t0, TMO);
        wait_done(100);
`else
        issue(0, 32'h3000_0300, 4'hF, 0, -1, 0, 0, 0);
        repeat (1000) @(negedge wb_clk_i);
        check("no_timeout_stb_held", wbm_stb_o, 1);
        reset_mid();
        t0 = 0; t1 = 0;
`endif

        // Randomized commands over a small window so reads hit earlier writes.
        rsp_rand = 1; wd_rand = 1; slv_waits = -1;
        for (int n = 0; n < 40; n++) begin
            a   = 32'h4000_0000 + 32'($urandom_range(0, 63) * 4);
            len = $urandom_range(0, 7);
            eb  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
            issue($urandom_range(0, 1) == 1, a, 4'($urandom_range(1, 15)), len, eb, -1, 0, 0);
            wait_done(500);
        end

        // Address wrap across 2^32 and the maximum burst length.
        issue(1, 32'hFFFF_FFF8, 4'hF, 3, -1, -1, 0, 0);
        wait_done(500);
        issue(0, 32'hFFFF_FFF8, 4'hF, 3, -1, -1, 0, 0);
        wait_done(500);
        issue(0, 32'hFFFF_FF00, 4'hF, 255, -1, -1, 0, 0);
        wait_done(4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Wishbone classic bus initiator that turns a valid/ready command stream into single or incrementing-burst read/write cycles. It returns one response per beat. It sits between a user-area controller (sequencer, test engine, LA-driven debug port) and Wishbone slaves such as the AES wrapper. It is the master-side counterpart of the existing wbs_* slave ports.

## Interface
- AW, 32: address width
- DW, 32: data width; SEL width is DW/8
- LEN_W, 8: burst length field width (beats minus one)
- TIMEOUT_CYCLES, 255: watchdog limit in REQ (used only with the macro)

Ports:
- wb_clk_i  in  1  single clock; every flop is on its rising edge
- wb_rst_n_i  in  1  asynchronous active-low reset
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  AW  byte address of first beat
- cmd_sel_i  in  DW/8  byte lanes, constant for the whole burst
- cmd_len_i  in  LEN_W  beats minus one
- wdata_valid_i / wdata_ready_o  in/out  1  write-data handshake, one per write beat
- wdata_i  in  DW  write data
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake, one per beat
- rsp_dat_o  out  DW  read data; 0 for writes and errors
- rsp_err_o  out  1  beat terminated by wbm_err_i or timeout
- rsp_last_o  out  1  final response of the command
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone master controls
- wbm_adr_o  out  AW; wbm_sel_o  out  DW/8; wbm_dat_o  out  DW
- wbm_ack_i, wbm_err_i  in  1; wbm_dat_i  in  DW
- busy_o  out  1  state is not IDLE

## Operation
States and transitions:
- IDLE: cmd_ready_o=1.
  - On a command handshake: latch adr/we/sel, set remaining=cmd_len_i, assert cyc.
  - Go to WDATA if we=1, otherwise REQ.
- WDATA: wdata_ready_o=1. On handshake, latch wdata_i into wbm_dat_o and go to REQ.
- REQ: stb=1 with adr/we/sel/dat stable.
  - On wbm_ack_i or wbm_err_i: capture wbm_dat_i for reads, record err, drop stb, go to RSP.
- RSP: rsp_valid_o=1, held with stable data until rsp_ready_i.
  - Terminate if remaining==0 or err: set rsp_last_o=1, go to IDLE, drop cyc.
  - Otherwise: remaining-1, adr+DW/8, go to WDATA or REQ.

Bus and arithmetic rules:
- cyc stays high for the whole burst, including RSP and WDATA stalls, so the bus is held.
- stb is high only in REQ.
- Address increment wraps modulo 2^AW. Remaining is unsigned, and the decrement never underflows because 0 terminates.
- Beats per command: cmd_len_i+1, so up to 2^LEN_W.

Boundary conditions:
- ack and err in the same cycle: err wins, rsp_dat_o=0, burst ends.
- Error on a non-final beat: that beat reports rsp_err_o=1 and rsp_last_o=1; the remaining beats are dropped.
- cmd_valid_i while not IDLE: ignored, with cmd_ready_o=0.
- Reset asserted mid-burst: cyc/stb/rsp_valid drop immediately (asynchronous), state returns to IDLE, and in-flight data is discarded.

## Timing
- Reset values:
  - All wbm_* outputs, rsp_* outputs, wdata_ready_o and busy_o are 0.
  - cmd_ready_o is 1 (decoded from IDLE).
- Latencies:
  - Read command handshake at edge N: cyc/stb high after N.
  - Ack sampled at edge M: stb low and rsp_valid_o high after M.
- Minimum per-beat cost with a zero-wait slave and rsp_ready_i=1:
  - Read: 2 cycles (REQ, RSP).
  - Write: 3 cycles (WDATA, REQ, RSP).
- All outputs are registered or decoded only from state. There is no combinational path from wbm_ack_i to any output.

## Configuration
- WB_INITIATOR_TIMEOUT_EN defined:
  - A counter runs in REQ and clears on entry.
  - When it reaches TIMEOUT_CYCLES without ack/err, the beat completes as an error: rsp_err_o=1, rsp_dat_o=0, rsp_last_o=1, cyc/stb drop.
- Not defined: no counter; REQ waits indefinitely for ack/err.

## Structure
- Package wb_initiator_pkg: state enum (IDLE, WDATA, REQ, RSP) and the byte-stride constant derivation.
- Sub-module wb_initiator_wdog: the timeout counter, clear/enable/expired interface. It is instantiated only under WB_INITIATOR_TIMEOUT_EN.

## Test plan
- Single read: adr=0x3000_0004, len=0, slave acks after 2 waits with 0xDEAD_BEEF.
  - One response: dat=0xDEAD_BEEF, err=0, last=1.
  - cyc is low the cycle after the response handshake.
- Write burst: adr=0x3000_0000, len=3, sel=0xF, data 1..4.
  - Slave sees adr 0x..00/04/08/0C with dat 1..4 and we=1.
  - 4 responses; last=1 only on the 4th.
  - cyc is continuous across the burst.
- Response backpressure: read len=1, rsp_ready_i low for 5 cycles on beat 0.
  - rsp_dat_o and rsp_valid_o stay stable.
  - No second stb until the handshake completes.
- Error mid-burst: read len=3, slave asserts err together with ack on beat 1.
  - Beat 1 response has err=1, dat=0, last=1.
  - Only 2 bus cycles are issued; state returns to IDLE.
- Timeout (macro on, TIMEOUT_CYCLES=16): slave never acks.
  - Error response with last=1 exactly 16 cycles after stb rises.
  - Without the macro, stb is still high after 1000 cycles.
- Reset mid-burst: assert wb_rst_n_i low during REQ of beat 2.
  - cyc/stb/rsp_valid are 0 before the next edge.
  - After release, cmd_ready_o=1 and a new single read completes normally.
